// File: rtl/dm_arbiter.sv
// Two-port (instruction fetch / execute) arbiter in front of a single-port memory.
// Define DM_ARB_RR_EN for round-robin arbitration; otherwise EX has fixed priority.
module dm_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              ex_ack_o,
  output logic [DATA_W-1:0] ex_rdata_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                gnt_ex_q, gnt_ex_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   ex_rdata_q, ex_rdata_d;
  logic                pick_ex;

`ifdef DM_ARB_RR_EN
  // last_ex_q = 1 when EX took the most recent grant; reset value lets EX win first.
  logic last_ex_q, last_ex_d;

  assign pick_ex = ex_req_i && (!if_req_i || !last_ex_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_ex_q <= 1'b0;
    else     last_ex_q <= last_ex_d;
  end

  always_comb begin
    last_ex_d = last_ex_q;
    if (state_q == IDLE && (if_req_i || ex_req_i)) last_ex_d = pick_ex;
  end
`else
  assign pick_ex = ex_req_i;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create ordering races.
  // NOTE: the read-data holding registers are reset too, because every output
  // must read 0 while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_ex_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      ex_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_ex_q   <= gnt_ex_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      ex_rdata_q <= ex_rdata_d;
    end
  end

  // NOTE: every signal gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_ex_d   = gnt_ex_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_data_d  = if_data_q;
    ex_rdata_d = ex_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (if_req_i || ex_req_i) begin
          gnt_ex_d = pick_ex;
          we_d     = pick_ex && ex_we_i;
          addr_d   = pick_ex ? ex_addr_i : if_addr_i;
          wdata_d  = pick_ex ? ex_wdata_i : '0;
          cnt_d    = CNT_INIT;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (gnt_ex_q) ex_rdata_d = mem_rdata_i;
            else          if_data_d  = mem_rdata_i;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_cs_o    = (state_q == ACCESS);
  assign mem_we_o    = (state_q == ACCESS) && we_q;
  assign mem_addr_o  = (state_q == ACCESS) ? addr_q  : '0;
  assign mem_wdata_o = (state_q == ACCESS) ? wdata_q : '0;
  assign if_ack_o    = (state_q == RESP) && !gnt_ex_q;
  assign ex_ack_o    = (state_q == RESP) &&  gnt_ex_q;
  assign if_data_o   = if_data_q;
  assign ex_rdata_o  = ex_rdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench: instance 0 runs WAIT_CYCLES=1, instance 1 runs WAIT_CYCLES=3.
module tb_dm_arbiter;

`ifdef DM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk, rst;
  logic [1:0]       if_req, ex_req, ex_we;
  logic [1:0][15:0] if_addr, ex_addr;
  logic [1:0][31:0] ex_wdata, mem_rdata;
  logic [1:0]       if_ack, ex_ack, mem_cs, mem_we, busy;
  logic [1:0][15:0] mem_addr;
  logic [1:0][31:0] if_data, ex_rdata, mem_wdata;

  int total = 0;
  int bad   = 0;

  dm_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_ack_o(if_ack[0]), .if_data_o(if_data[0]),
    .ex_req_i(ex_req[0]), .ex_we_i(ex_we[0]), .ex_addr_i(ex_addr[0]), .ex_wdata_i(ex_wdata[0]),
    .ex_ack_o(ex_ack[0]), .ex_rdata_o(ex_rdata[0]),
    .mem_cs_o(mem_cs[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0])
  );

  dm_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_ack_o(if_ack[1]), .if_data_o(if_data[1]),
    .ex_req_i(ex_req[1]), .ex_we_i(ex_we[1]), .ex_addr_i(ex_addr[1]), .ex_wdata_i(ex_wdata[1]),
    .ex_ack_o(ex_ack[1]), .ex_rdata_o(ex_rdata[1]),
    .mem_cs_o(mem_cs[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, "_busy"},  64'(busy[d]),      64'd0);
    check({tag, "_ifack"}, 64'(if_ack[d]),    64'd0);
    check({tag, "_exack"}, 64'(ex_ack[d]),    64'd0);
    check({tag, "_cs"},    64'(mem_cs[d]),    64'd0);
    check({tag, "_we"},    64'(mem_we[d]),    64'd0);
    check({tag, "_addr"},  64'(mem_addr[d]),  64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata[d]), 64'd0);
    check({tag, "_ifdat"}, 64'(if_data[d]),   64'd0);
    check({tag, "_exdat"}, 64'(ex_rdata[d]),  64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req = '0;
    ex_req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request on instance d and wait (bounded) for its ack; every
  // access cycle is checked against the requested address/we/wdata.
  task automatic run_req(input int d, input bit is_ex, input bit we,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input bit mutate,
                         input string tag, output int lat, output int cs_n);
    bit done = 1'b0;
    bit other_seen = 1'b0;
    @(negedge clk);
    mem_rdata[d] = rdata;
    if (is_ex) begin
      ex_req[d] = 1'b1; ex_we[d] = we; ex_addr[d] = addr; ex_wdata[d] = wdata;
    end else begin
      if_req[d] = 1'b1; if_addr[d] = addr;
    end
    lat  = 0;
    cs_n = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_cs[d]) begin
        cs_n++;
        check({tag, "_addr"}, 64'(mem_addr[d]), 64'(addr));
        check({tag, "_we"},   64'(mem_we[d]),   64'(we));
        if (we) check({tag, "_wdata"}, 64'(mem_wdata[d]), 64'(wdata));
      end else begin
        check({tag, "_idle_addr"}, 64'(mem_addr[d]), 64'd0);
        check({tag, "_idle_we"},   64'(mem_we[d]),   64'd0);
      end
      if (mutate) begin
        if_addr[d] = ~addr; ex_addr[d] = ~addr; ex_wdata[d] = ~wdata; ex_we[d] = ~we;
      end
      if (is_ex ? if_ack[d] : ex_ack[d]) other_seen = 1'b1;
      if (is_ex ? ex_ack[d] : if_ack[d]) done = 1'b1;
    end
    check({tag, "_acked"}, 64'(done), 64'd1);
    check({tag, "_other_ack"}, 64'(other_seen), 64'd0);
    if_req[d] = 1'b0;
    ex_req[d] = 1'b0;
  endtask

  initial begin
    int lat, cs_n, cyc, ex_at, if_at, n, last_at;
    logic [3:0] order;

    rst = 1'b1;
    if_req = '0; ex_req = '0; ex_we = '0;
    if_addr = '0; ex_addr = '0; ex_wdata = '0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check_zero(0, "rst0");
    check_zero(1, "rst1");
    rst = 1'b0;

    // WAIT_CYCLES=1 load
    run_req(0, 1'b1, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "ld1", lat, cs_n);
    check("ld1_lat", 64'(lat), 64'd2);
    check("ld1_cs",  64'(cs_n), 64'd1);
    check("ld1_data", 64'(ex_rdata[0]), 64'hDEAD_BEEF);
    check("ld1_ifdat", 64'(if_data[0]), 64'd0);
    @(negedge clk);
    check("ld1_busy_after", 64'(busy[0]), 64'd0);

    // WAIT_CYCLES=3 load, store, then IF read with inputs changed mid-access
    run_req(1, 1'b1, 1'b0, 16'h0030, 32'h0, 32'hA5A5_A5A5, 1'b0, "ld3", lat, cs_n);
    check("ld3_lat", 64'(lat), 64'd4);
    check("ld3_cs",  64'(cs_n), 64'd3);
    check("ld3_data", 64'(ex_rdata[1]), 64'hA5A5_A5A5);

    run_req(1, 1'b1, 1'b1, 16'h0020, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, "st3", lat, cs_n);
    check("st3_lat", 64'(lat), 64'd4);
    check("st3_cs",  64'(cs_n), 64'd3);
    check("st3_rdata_kept", 64'(ex_rdata[1]), 64'hA5A5_A5A5);

    run_req(1, 1'b0, 1'b0, 16'h0100, 32'h0, 32'h0BAD_F00D, 1'b1, "if3m", lat, cs_n);
    check("if3m_lat", 64'(lat), 64'd4);
    check("if3m_cs",  64'(cs_n), 64'd3);
    check("if3m_data", 64'(if_data[1]), 64'h0BAD_F00D);
    check("if3m_exdat", 64'(ex_rdata[1]), 64'hA5A5_A5A5);

    // Both requesters, each drops its request at its ack
    do_reset();
    @(negedge clk);
    mem_rdata[0] = 32'h1111_2222;
    ex_req[0] = 1'b1; ex_we[0] = 1'b0; ex_addr[0] = 16'h0040;
    if_req[0] = 1'b1; if_addr[0] = 16'h0050;
    cyc = 0; ex_at = 0; if_at = 0;
    while ((ex_at == 0 || if_at == 0) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (ex_ack[0]) begin ex_at = cyc; ex_req[0] = 1'b0; end
      if (if_ack[0]) begin if_at = cyc; if_req[0] = 1'b0; end
    end
    ex_req[0] = 1'b0; if_req[0] = 1'b0;
    check("both_ex_at", 64'(ex_at), 64'd2);
    check("both_if_at", 64'(if_at), 64'd5);
    check("both_ifdat", 64'(if_data[0]), 64'h1111_2222);

    // Both held for four grants: order depends on the arbitration build
    do_reset();
    @(negedge clk);
    ex_req[0] = 1'b1; if_req[0] = 1'b1;
    cyc = 0; n = 0; order = '0; last_at = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ex_ack[0] || if_ack[0]) begin
        order[n] = ex_ack[0];
        n++;
        last_at = cyc;
      end
    end
    ex_req[0] = 1'b0; if_req[0] = 1'b0;
    check("rr_grants", 64'(n), 64'd4);
    check("rr_order", 64'(order), RR_EN ? 64'b0101 : 64'b1111);
    check("rr_last_at", 64'(last_at), 64'd11);

    // Reset in the middle of a WAIT_CYCLES=3 IF access
    do_reset();
    @(negedge clk);
    mem_rdata[1] = 32'h7777_8888;
    if_req[1] = 1'b1; if_addr[1] = 16'h0200;
    @(negedge clk);
    check("abort_cs_before", 64'(mem_cs[1]), 64'd1);
    rst = 1'b1;
    #1;
    check_zero(1, "abort1");
    check_zero(0, "abort0");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_noack", 64'(if_ack[1]), 64'd0);
    end
    if_req[1] = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_noack", 64'(if_ack[1] | busy[1]), 64'd0);
    end
    run_req(1, 1'b0, 1'b0, 16'h0200, 32'h0, 32'h7777_8888, 1'b0, "rereq", lat, cs_n);
    check("rereq_lat", 64'(lat), 64'd4);
    check("rereq_data", 64'(if_data[1]), 64'h7777_8888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
